// File: rtl/fp_pkg.sv
// Shared types and constants for the peak-fit engine scheduler.
package fp_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } sched_state_t;

    localparam logic        OWN_REF      = 1'b0;
    localparam logic        OWN_SMP      = 1'b1;
    localparam logic [15:0] FIT_NUM_DFLT = 16'd21;
    localparam int unsigned PEAK_END_CNT = 48;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output and synchronous flush.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + (AW+1)'(1);
            else if (do_pop && !do_push)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fit_engine_sched.sv
// Arbitrates the shared peak-fit engine between the reference-comb request
// queue and the single per-sweep sample request, routing results by owner.
module fit_engine_sched
    import fp_pkg::*;
#(
    parameter int unsigned QDEPTH  = 8,
    parameter logic [15:0] FIT_NUM = FIT_NUM_DFLT,
    parameter logic [15:0] TIMEOUT = 16'd4096
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        AD_start,
    input  logic        ref_req,
    input  logic [15:0] ref_addr,
    input  logic        smp_req,
    input  logic [15:0] smp_addr,
    output logic        fit_start,
    output logic [15:0] fit_addr,
    output logic [15:0] fit_len,
    input  logic        fit_done,
    input  logic [31:0] fit_result,
    output logic [31:0] ref_peak,
    output logic        ref_peak_en,
    output logic [31:0] smp_result,
    output logic        smp_result_en,
    output logic [7:0]  ref_fit_cnt,
    output logic        overflow,
    output logic        timeout_err,
    output logic        busy
);
    sched_state_t state;
    sched_state_t state_nxt;
    logic [15:0]  wait_cnt;
    logic         owner;
    logic         smp_pend;
    logic [15:0]  smp_addr_q;
    logic [15:0]  fifo_dout;
    logic         fifo_full;
    logic         fifo_empty;
    logic         tmo_hit;
    logic         grant_smp;
    logic         grant_ref;
    logic         deliver;
    logic         tmo_set;

    sync_fifo #(.WIDTH(16), .DEPTH(QDEPTH)) u_ref_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .flush   (AD_start),
        .push    (ref_req && !AD_start),
        .pop     (grant_ref),
        .din     (ref_addr),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign tmo_hit = (wait_cnt == TIMEOUT - 16'd1);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // A new sweep never cancels an in-flight engine job; it is drained instead.
    always_comb begin
        state_nxt = state;
        if (AD_start) begin
            if (state != S_IDLE) state_nxt = S_DRAIN;
        end else begin
            case (state)
                S_IDLE:  if (smp_pend || !fifo_empty) state_nxt = S_WAIT;
                S_WAIT,
                S_DRAIN: if (fit_done || tmo_hit)     state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        grant_smp = !AD_start && (state == S_IDLE) && smp_pend;
        grant_ref = !AD_start && (state == S_IDLE) && !smp_pend && !fifo_empty;
        deliver   = !AD_start && (state == S_WAIT) && fit_done;
        tmo_set   = !AD_start && (state == S_WAIT) && !fit_done && tmo_hit;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            fit_start     <= 1'b0;
            fit_addr      <= '0;
            fit_len       <= '0;
            ref_peak      <= '0;
            ref_peak_en   <= 1'b0;
            smp_result    <= '0;
            smp_result_en <= 1'b0;
            ref_fit_cnt   <= '0;
            overflow      <= 1'b0;
            timeout_err   <= 1'b0;
            busy          <= 1'b0;
            owner         <= OWN_REF;
            smp_pend      <= 1'b0;
            smp_addr_q    <= '0;
            wait_cnt      <= '0;
        end else begin
            fit_len       <= FIT_NUM;
            fit_start     <= grant_smp || grant_ref;
            ref_peak_en   <= deliver && (owner == OWN_REF);
            smp_result_en <= deliver && (owner == OWN_SMP);
            busy          <= (state != S_IDLE) || !fifo_empty || smp_pend;
            wait_cnt      <= (AD_start || state == S_IDLE) ? '0 : wait_cnt + 16'd1;

            if (grant_smp) begin
                fit_addr <= smp_addr_q;
                owner    <= OWN_SMP;
            end else if (grant_ref) begin
                fit_addr <= fifo_dout;
                owner    <= OWN_REF;
            end

            if (deliver && owner == OWN_REF) begin
                ref_peak <= fit_result;
                if (ref_fit_cnt != 8'hFF) ref_fit_cnt <= ref_fit_cnt + 8'd1;
            end
            if (deliver && owner == OWN_SMP) smp_result <= fit_result;

            if (AD_start) begin
                overflow    <= 1'b0;
                timeout_err <= 1'b0;
                ref_fit_cnt <= '0;
                smp_pend    <= 1'b0;
            end else begin
                if (ref_req && fifo_full) overflow <= 1'b1;
                if (tmo_set) timeout_err <= 1'b1;
                if (smp_req) begin
                    smp_pend   <= 1'b1;
                    smp_addr_q <= smp_addr;
                end else if (grant_smp) begin
                    smp_pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fit_engine_sched.sv
// Self-checking bench for fit_engine_sched: directed scenarios plus a random
// run compared cycle by cycle against a queue-based reference model.
module tb_fit_engine_sched;
    import fp_pkg::*;

    localparam int unsigned QD   = 8;
    localparam logic [15:0] FN   = 16'd21;
    localparam int          TOUT = 4096;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        AD_start = 1'b0;
    logic        ref_req = 1'b0;
    logic [15:0] ref_addr = '0;
    logic        smp_req = 1'b0;
    logic [15:0] smp_addr = '0;
    logic        fit_start;
    logic [15:0] fit_addr;
    logic [15:0] fit_len;
    logic        fit_done = 1'b0;
    logic [31:0] fit_result = '0;
    logic [31:0] ref_peak;
    logic        ref_peak_en;
    logic [31:0] smp_result;
    logic        smp_result_en;
    logic [7:0]  ref_fit_cnt;
    logic        overflow;
    logic        timeout_err;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 sys_clk = ~sys_clk;

    fit_engine_sched #(.QDEPTH(QD), .FIT_NUM(FN), .TIMEOUT(16'(TOUT))) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .AD_start(AD_start),
        .ref_req(ref_req), .ref_addr(ref_addr), .smp_req(smp_req), .smp_addr(smp_addr),
        .fit_start(fit_start), .fit_addr(fit_addr), .fit_len(fit_len),
        .fit_done(fit_done), .fit_result(fit_result),
        .ref_peak(ref_peak), .ref_peak_en(ref_peak_en),
        .smp_result(smp_result), .smp_result_en(smp_result_en),
        .ref_fit_cnt(ref_fit_cnt), .overflow(overflow),
        .timeout_err(timeout_err), .busy(busy)
    );

    wire [109:0] dut_vec = {fit_start, fit_addr, fit_len, ref_peak, ref_peak_en, smp_result,
                            smp_result_en, ref_fit_cnt, overflow, timeout_err, busy};

    // Reference model: pending work as a queue plus a pending-sample flag,
    // engine phase 0 = free, 1 = serving a job, 2 = discarding a stale job.
    logic [15:0] mq[$];
    bit          m_pend;
    logic [15:0] m_paddr;
    int          m_phase;
    int          m_wait;
    bit          m_owner_smp;
    logic        e_start, e_rpk_en, e_smp_en, e_ovf, e_to, e_busy;
    logic [15:0] e_addr, e_len;
    logic [31:0] e_rpk, e_smp;
    logic [7:0]  e_cnt;

    task automatic model_step();
        int  qn;
        bit  tout;
        if (sys_rst) begin
            mq.delete(); m_pend = 0; m_paddr = '0; m_phase = 0; m_wait = 0; m_owner_smp = 0;
            e_start = 0; e_addr = '0; e_len = '0; e_rpk = '0; e_rpk_en = 0; e_smp = '0;
            e_smp_en = 0; e_cnt = '0; e_ovf = 0; e_to = 0; e_busy = 0;
            return;
        end
        e_busy = (m_phase != 0) || (mq.size() != 0) || m_pend;
        e_len = FN; e_start = 0; e_rpk_en = 0; e_smp_en = 0;
        qn = mq.size();
        tout = (m_wait == TOUT - 1);
        if (AD_start) begin
            mq.delete(); m_pend = 0; e_ovf = 0; e_to = 0; e_cnt = '0;
            if (m_phase != 0) begin m_phase = 2; m_wait = 0; end
        end else begin
            if (m_phase == 0) begin
                if (m_pend) begin
                    e_start = 1; e_addr = m_paddr; m_owner_smp = 1; m_pend = 0; m_phase = 1; m_wait = 0;
                end else if (qn > 0) begin
                    e_start = 1; e_addr = mq.pop_front(); m_owner_smp = 0; m_phase = 1; m_wait = 0;
                end
            end else if (m_phase == 1) begin
                if (fit_done) begin
                    if (m_owner_smp) begin e_smp = fit_result; e_smp_en = 1; end
                    else begin
                        e_rpk = fit_result; e_rpk_en = 1;
                        if (e_cnt != 8'd255) e_cnt = e_cnt + 8'd1;
                    end
                    m_phase = 0;
                end else if (tout) begin e_to = 1; m_phase = 0; end
                else m_wait++;
            end else begin
                if (fit_done || tout) m_phase = 0;
                else m_wait++;
            end
            if (ref_req) begin
                if (qn >= int'(QD)) e_ovf = 1;
                else mq.push_back(ref_addr);
            end
            if (smp_req) begin m_pend = 1; m_paddr = smp_addr; end
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        model_step();
        #1;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (fit_start === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic engine_done(input logic [31:0] r);
        fit_done = 1'b1; fit_result = r;
        tick();
        fit_done = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (2) tick();
        n_chk++; if (dut_vec !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", dut_vec); end
        sys_rst = 1'b0;
        tick();
        n_chk++; if (fit_len !== FN) begin n_err++; $display("FAIL reset_fit_len: got %0d want %0d", fit_len, FN); end
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_ref();
        ref_req = 1'b1; ref_addr = 16'h0100;
        tick();
        ref_req = 1'b0;
        n_chk++; if (fit_start !== 1'b0) begin n_err++; $display("FAIL single_early_start: got %b want 0", fit_start); end
        tick();
        n_chk++; if (fit_start !== 1'b1) begin n_err++; $display("FAIL single_start_latency: got %b want 1", fit_start); end
        n_chk++; if (fit_addr !== 16'h0100) begin n_err++; $display("FAIL single_fit_addr: got %h want 0100", fit_addr); end
        repeat (29) tick();
        engine_done(32'h1234_05F6);
        n_chk++; if (ref_peak_en !== 1'b1) begin n_err++; $display("FAIL single_peak_en: got %b want 1", ref_peak_en); end
        n_chk++; if (ref_peak !== 32'h1234_05F6) begin n_err++; $display("FAIL single_peak: got %h want 123405f6", ref_peak); end
        n_chk++; if (ref_fit_cnt !== 8'd1) begin n_err++; $display("FAIL single_cnt: got %0d want 1", ref_fit_cnt); end
        tick();
        n_chk++; if (ref_peak_en !== 1'b0) begin n_err++; $display("FAIL single_peak_en_pulse: got %b want 0", ref_peak_en); end
    endtask

    task automatic test_burst_overflow();
        bit ok;
        AD_start = 1'b1; tick(); AD_start = 1'b0;
        smp_req = 1'b1; smp_addr = 16'h0555; tick(); smp_req = 1'b0;
        wait_start(ok);
        n_chk++; if (!ok || fit_addr !== 16'h0555) begin n_err++; $display("FAIL burst_hold_grant: got ok=%b addr=%h want 1 0555", ok, fit_addr); end
        for (int i = 0; i < 10; i++) begin
            ref_req = 1'b1; ref_addr = 16'(16'h0010 + i);
            tick();
            if (i == 7) begin
                n_chk++; if (overflow !== 1'b0) begin n_err++; $display("FAIL burst_no_overflow_at_8: got %b want 0", overflow); end
            end
        end
        ref_req = 1'b0;
        n_chk++; if (overflow !== 1'b1) begin n_err++; $display("FAIL burst_overflow: got %b want 1", overflow); end
        engine_done(32'hAAAA_0001);
        n_chk++; if (smp_result_en !== 1'b1 || ref_peak_en !== 1'b0) begin n_err++; $display("FAIL burst_smp_route: got smp_en=%b ref_en=%b want 1 0", smp_result_en, ref_peak_en); end
        for (int i = 0; i < 8; i++) begin
            wait_start(ok);
            n_chk++; if (!ok || fit_addr !== 16'(16'h0010 + i)) begin n_err++; $display("FAIL burst_order_%0d: got ok=%b addr=%h want %h", i, ok, fit_addr, 16'(16'h0010 + i)); end
            repeat (3) tick();
            engine_done({16'h00C0, 16'(16'h0010 + i)});
            n_chk++; if (ref_peak_en !== 1'b1 || ref_peak !== {16'h00C0, 16'(16'h0010 + i)}) begin n_err++; $display("FAIL burst_result_%0d: got en=%b peak=%h", i, ref_peak_en, ref_peak); end
        end
        n_chk++; if (ref_fit_cnt !== 8'd8) begin n_err++; $display("FAIL burst_cnt: got %0d want 8", ref_fit_cnt); end
        repeat (2) tick();
        n_chk++; if (busy !== 1'b0 || overflow !== 1'b1) begin n_err++; $display("FAIL burst_idle: got busy=%b ovf=%b want 0 1", busy, overflow); end
    endtask

    task automatic test_priority();
        bit ok;
        ref_req = 1'b1; ref_addr = 16'h0020; tick(); ref_req = 1'b0;
        wait_start(ok);
        n_chk++; if (!ok || fit_addr !== 16'h0020) begin n_err++; $display("FAIL prio_first: got ok=%b addr=%h want 1 0020", ok, fit_addr); end
        for (int i = 0; i < 3; i++) begin
            ref_req = 1'b1; ref_addr = 16'(16'h0021 + i); tick();
        end
        ref_req = 1'b0;
        smp_req = 1'b1; smp_addr = 16'h0800; tick(); smp_req = 1'b0;
        repeat (2) tick();
        engine_done(32'h0000_0020);
        wait_start(ok);
        n_chk++; if (!ok || fit_addr !== 16'h0800) begin n_err++; $display("FAIL prio_sample_first: got ok=%b addr=%h want 1 0800", ok, fit_addr); end
        repeat (2) tick();
        engine_done(32'h5555_0800);
        n_chk++; if (smp_result_en !== 1'b1 || ref_peak_en !== 1'b0 || smp_result !== 32'h5555_0800) begin n_err++; $display("FAIL prio_smp_route: got smp_en=%b ref_en=%b res=%h", smp_result_en, ref_peak_en, smp_result); end
        for (int i = 0; i < 3; i++) begin
            wait_start(ok);
            n_chk++; if (!ok || fit_addr !== 16'(16'h0021 + i)) begin n_err++; $display("FAIL prio_ref_%0d: got ok=%b addr=%h", i, ok, fit_addr); end
            engine_done(32'h0000_0021 + i);
        end
    endtask

    task automatic test_ad_start();
        bit ok;
        bit stray;
        ref_req = 1'b1; ref_addr = 16'h0030; tick(); ref_req = 1'b0;
        wait_start(ok);
        for (int i = 0; i < 4; i++) begin
            ref_req = 1'b1; ref_addr = 16'(16'h0031 + i); tick();
        end
        ref_req = 1'b0;
        n_chk++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ad_sticky_before: got %b want 1", overflow); end
        AD_start = 1'b1; ref_req = 1'b1; ref_addr = 16'h0099; smp_req = 1'b1; smp_addr = 16'h0999;
        tick();
        AD_start = 1'b0; ref_req = 1'b0; smp_req = 1'b0;
        n_chk++; if (overflow !== 1'b0 || timeout_err !== 1'b0 || ref_fit_cnt !== 8'd0) begin n_err++; $display("FAIL ad_clear: got ovf=%b to=%b cnt=%0d want 0 0 0", overflow, timeout_err, ref_fit_cnt); end
        stray = 1'b0;
        repeat (5) begin tick(); if (fit_start !== 1'b0) stray = 1'b1; end
        n_chk++; if (stray || busy !== 1'b1) begin n_err++; $display("FAIL ad_drain: got stray_start=%b busy=%b want 0 1", stray, busy); end
        engine_done(32'hDEAD_BEEF);
        n_chk++; if (ref_peak_en !== 1'b0 || smp_result_en !== 1'b0) begin n_err++; $display("FAIL ad_discard: got ref_en=%b smp_en=%b want 0 0", ref_peak_en, smp_result_en); end
        tick();
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL ad_busy_clear: got %b want 0", busy); end
        stray = 1'b0;
        repeat (3) begin tick(); if (fit_start !== 1'b0) stray = 1'b1; end
        n_chk++; if (stray) begin n_err++; $display("FAIL ad_no_grant: got stray start want none"); end
    endtask

    task automatic test_timeout();
        bit ok;
        ref_req = 1'b1; ref_addr = 16'h0040; tick(); ref_req = 1'b0;
        wait_start(ok);
        n_chk++; if (!ok || fit_addr !== 16'h0040) begin n_err++; $display("FAIL tmo_grant: got ok=%b addr=%h", ok, fit_addr); end
        ref_req = 1'b1; ref_addr = 16'h0041; tick(); ref_req = 1'b0;
        repeat (TOUT - 2) tick();
        n_chk++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_early: got %b want 0", timeout_err); end
        tick();
        n_chk++; if (timeout_err !== 1'b1 || ref_peak_en !== 1'b0) begin n_err++; $display("FAIL tmo_flag: got to=%b ref_en=%b want 1 0", timeout_err, ref_peak_en); end
        wait_start(ok);
        n_chk++; if (!ok || fit_addr !== 16'h0041) begin n_err++; $display("FAIL tmo_next_grant: got ok=%b addr=%h want 1 0041", ok, fit_addr); end
        engine_done(32'h0001_0041);
        n_chk++; if (ref_peak_en !== 1'b1 || ref_fit_cnt !== 8'd1) begin n_err++; $display("FAIL tmo_recover: got en=%b cnt=%0d want 1 1", ref_peak_en, ref_fit_cnt); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit stray;
        ref_req = 1'b1; ref_addr = 16'h0050; tick(); ref_req = 1'b0;
        wait_start(ok);
        for (int i = 0; i < 5; i++) begin
            ref_req = 1'b1; ref_addr = 16'(16'h0051 + i); tick();
        end
        ref_req = 1'b0;
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        n_chk++; if (dut_vec !== '0) begin n_err++; $display("FAIL rstmid_outputs: got %h want 0", dut_vec); end
        engine_done(32'hFFFF_FFFF);
        n_chk++; if (ref_peak_en !== 1'b0 || smp_result_en !== 1'b0) begin n_err++; $display("FAIL rstmid_late_done: got ref_en=%b smp_en=%b want 0 0", ref_peak_en, smp_result_en); end
        stray = 1'b0;
        repeat (4) begin tick(); if (fit_start !== 1'b0) stray = 1'b1; end
        n_chk++; if (stray || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_fifo_empty: got stray=%b busy=%b want 0 0", stray, busy); end
    endtask

    task automatic test_random();
        int cd;
        int shown;
        logic [109:0] exp_vec;
        cd = 0; shown = 0;
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            ref_req  = ($urandom_range(0, 3) == 0);
            ref_addr = 16'($urandom);
            smp_req  = ($urandom_range(0, 39) == 0);
            smp_addr = 16'($urandom);
            AD_start = ($urandom_range(0, 299) == 0);
            fit_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin fit_done = 1'b1; fit_result = $urandom; end
            end else if ($urandom_range(0, 99) == 0) begin
                fit_done = 1'b1; fit_result = $urandom;
            end
            tick();
            exp_vec = {e_start, e_addr, e_len, e_rpk, e_rpk_en, e_smp, e_smp_en, e_cnt, e_ovf, e_to, e_busy};
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_err++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_cycle_%0d: got %h want %h", c, dut_vec, exp_vec);
                end
            end
            if (fit_start === 1'b1) cd = $urandom_range(1, 12);
        end
        ref_req = 1'b0; smp_req = 1'b0; AD_start = 1'b0; fit_done = 1'b0;
        n_chk++; if (mq.size() > QD) begin n_err++; $display("FAIL random_queue_bound: got %0d want <= %0d", mq.size(), QD); end
    endtask

    initial begin
        test_reset();
        test_single_ref();
        test_burst_overflow();
        test_priority();
        test_ad_start();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
